// File: rtl/p_mul_ctrl.sv
`timescale 1ns/1ps
// p_mul_ctrl: round-robin sequencer sharing one packed multiplier between two requesters.
// Latency: accept to response N+1 cycles (N = lane width + 1); 1 cycle for an op rejected by P_MUL_CTRL_PW_CHECK_EN.
// Backpressure: one op in flight, both reqN_ready low outside IDLE; the response is held until rspN_ready.
module p_mul_ctrl #(
  parameter int RR_INIT = 0
) (
  input  logic        clock,
  input  logic        resetn,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_op,
  input  logic [31:0] req0_crs1,
  input  logic [31:0] req0_crs2,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_op,
  input  logic [31:0] req1_crs1,
  input  logic [31:0] req1_crs2,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_error,

  output logic        mul_valid,
  input  logic        mul_ready,
  output logic        mul_l,
  output logic        mul_h,
  output logic        clmul,
  output logic [4:0]  mul_pw,
  output logic [31:0] mul_crs1,
  output logic [31:0] mul_crs2,
  input  logic [31:0] mul_result
);

  typedef struct packed {
    logic [4:0] pw;
    logic       clmul;
    logic       mul_h;
    logic       mul_l;
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic RR_INIT_PORT = (RR_INIT != 0);

  state_t      state_q, state_d;
  logic        ptr_q;
  logic        gnt_q;
  op_t         op_q;
  logic [31:0] crs1_q, crs2_q;
  logic [31:0] result_q;

  logic        win;
  logic        accept;
  op_t         win_op;
  logic [31:0] win_crs1, win_crs2;
  logic        op_bad;
  logic        rsp_done;

  // Grant only in IDLE; on contention the priority pointer picks the winner.
  always_comb begin
    win        = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        win = ptr_q;
      end else begin
        win = req1_valid;
      end
      req0_ready = req0_valid && !win;
      req1_ready = req1_valid &&  win;
    end
  end

  assign accept   = req0_ready | req1_ready;
  assign win_op   = win ? op_t'(req1_op) : op_t'(req0_op);
  assign win_crs1 = win ? req1_crs1 : req0_crs1;
  assign win_crs2 = win ? req1_crs2 : req0_crs2;

`ifdef P_MUL_CTRL_PW_CHECK_EN
  // Legal widths are a single one of pw[3:0]; pw[4] is reserved.
  assign op_bad = !($onehot(win_op.pw[3:0]) && !win_op.pw[4]);
`else
  assign op_bad = 1'b0;
`endif

  assign rsp_done = (state_q == RESP) && (gnt_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = op_bad ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (mul_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ptr_q    <= RR_INIT_PORT;
      gnt_q    <= 1'b0;
      op_q     <= '0;
      crs1_q   <= '0;
      crs2_q   <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q  <= !win;
        gnt_q  <= win;
        op_q   <= win_op;
        crs1_q <= win_crs1;
        crs2_q <= win_crs2;
      end
      if (accept && op_bad) begin
        result_q <= '0;
      end else if (mul_valid && mul_ready) begin
        result_q <= mul_result;
      end
    end
  end

`ifdef P_MUL_CTRL_PW_CHECK_EN
  logic error_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      error_q <= 1'b0;
    end else if (accept) begin
      error_q <= op_bad;
    end
  end

  assign rsp_error = error_q;
`else
  assign rsp_error = 1'b0;
`endif

  // Valid is decoded straight from the state register so reset drops it at once.
  assign mul_valid  = (state_q == BUSY);
  assign rsp0_valid = (state_q == RESP) && !gnt_q;
  assign rsp1_valid = (state_q == RESP) &&  gnt_q;
  assign rsp_result = result_q;

  assign mul_l    = op_q.mul_l;
  assign mul_h    = op_q.mul_h;
  assign clmul    = op_q.clmul;
  assign mul_pw   = op_q.pw;
  assign mul_crs1 = crs1_q;
  assign mul_crs2 = crs2_q;

endmodule

// File: tb/tb_p_mul_ctrl.sv
`timescale 1ns/1ps
// Bench for p_mul_ctrl: behavioural packed multiplier plus a lane-arithmetic reference model.
module tb_p_mul_ctrl;

  localparam int RR_INIT = 0;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_crs1 = '0, req0_crs2 = '0, req1_crs1 = '0, req1_crs2 = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_error;
  logic        m_valid, m_ready, m_l, m_h, m_clmul;
  logic [4:0]  m_pw;
  logic [31:0] m_crs1, m_crs2, m_result;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic ptr_m = (RR_INIT != 0);
  int   mcnt;

  p_mul_ctrl #(.RR_INIT(RR_INIT)) dut (
    .clock(clock), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_crs1(req0_crs1), .req0_crs2(req0_crs2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_crs1(req1_crs1), .req1_crs2(req1_crs2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .mul_valid(m_valid), .mul_ready(m_ready),
    .mul_l(m_l), .mul_h(m_h), .clmul(m_clmul), .mul_pw(m_pw),
    .mul_crs1(m_crs1), .mul_crs2(m_crs2), .mul_result(m_result)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1);
  end

  // pw[3]=32, pw[2]=16, pw[1]=8, pw[0]=4 bit lanes.
  function automatic int lane_w(input logic [4:0] pw);
    if (pw[3]) return 32;
    if (pw[2]) return 16;
    if (pw[1]) return 8;
    return 4;
  endfunction

  function automatic logic [31:0] pmul(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    logic [31:0] r;
    longint unsigned x, y, p, mask;
    w = lane_w(op[7:3]);
    r = '0;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < 32 / w; i++) begin
      x = (64'(a) >> (i * w)) & mask;
      y = (64'(b) >> (i * w)) & mask;
      if (op[2]) begin
        p = 0;
        for (int j = 0; j < w; j++) if (y[j]) p = p ^ (x << j);
      end else begin
        p = x * y;
      end
      p = op[1] ? ((p >> w) & mask) : (p & mask);
      r = r | 32'(p << (i * w));
    end
    return r;
  endfunction

  // Multiplier: finishes in its (w+1)-th valid cycle, restarts if valid stays high.
  assign m_result = pmul({m_pw, m_clmul, m_h, m_l}, m_crs1, m_crs2);
  assign m_ready  = m_valid && (mcnt == lane_w(m_pw));

  always @(posedge clock or negedge resetn) begin
    if (!resetn) mcnt <= 0;
    else if (m_valid && !m_ready) mcnt <= mcnt + 1;
    else mcnt <= 0;
  end

  function automatic logic rdy_of(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rspv_of(input int p);
    return (p == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  task automatic drive_req(input int port, input logic v, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      req0_valid = v; req0_op = op; req0_crs1 = a; req0_crs2 = b;
    end else begin
      req1_valid = v; req1_op = op; req1_crs1 = a; req1_crs2 = b;
    end
  endtask

  task automatic set_rsp_ready(input int port, input logic v);
    if (port == 0) rsp0_ready = v;
    else rsp1_ready = v;
  endtask

  // Runs one transaction on a single port and reports what was observed.
  task automatic run_op(input int port, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output int lat, output int vcnt, output logic [31:0] res,
                        output logic err, output bit stable, output bit ok);
    int t0, n;
    bit got;
    ok = 1; stable = 1; vcnt = 0; lat = -1; res = '0; err = 1'b0;
    @(negedge clock);
    drive_req(port, 1'b1, op, a, b);
    #1;
    n = 0;
    while (!rdy_of(port) && n < 100) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 100) begin
      ok = 0;
      drive_req(port, 1'b0, op, a, b);
      return;
    end
    t0 = cyc;
    ptr_m = (port == 0);
    @(negedge clock);
    drive_req(port, 1'b0, op, a, b);
    n = 0; got = 0;
    while (!got && n < 200) begin
      #1;
      if (m_valid) vcnt++;
      if (rspv_of(1 - port)) ok = 0;
      if (rspv_of(port)) begin
        got = 1; lat = cyc - t0; res = rsp_result; err = rsp_error;
      end else begin
        @(negedge clock); n++;
      end
    end
    if (!got) begin
      ok = 0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock); #1;
      if (!rspv_of(port) || rsp_result !== res || rsp_error !== err || m_valid) stable = 0;
    end
    set_rsp_ready(port, 1'b1);
    @(negedge clock); #1;
    if (rspv_of(port)) stable = 0;
    set_rsp_ready(port, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    #1;
    vectors++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, m_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b want 00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, m_valid});
    end
    vectors++;
    if ({m_l, m_h, m_clmul, m_pw} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mul_op: got %h want 00", {m_l, m_h, m_clmul, m_pw});
    end
    vectors++;
    if ({m_crs1, m_crs2, rsp_result, rsp_error} !== 97'b0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h %h %b want zeros", m_crs1, m_crs2, rsp_result, rsp_error);
    end
    resetn = 1'b1;
    ptr_m = (RR_INIT != 0);
    repeat (2) @(negedge clock);
    #1;
    vectors++;
    if ({m_valid, rsp0_valid, rsp1_valid} !== 3'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b want 000", {m_valid, rsp0_valid, rsp1_valid});
    end
  endtask

  task automatic test_mul_l_basic();
    int lat, vcnt; logic [31:0] res; logic err; bit stable, ok;
    run_op(0, 8'b01000_0_0_1, 32'd3, 32'd5, 0, lat, vcnt, res, err, stable, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_handshake: got %0d want 1", ok); end
    vectors++; if (vcnt !== 33) begin miscompares++; $display("FAIL basic_valid_cycles: got %0d want 33", vcnt); end
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL basic_latency: got %0d want 34", lat); end
    vectors++; if (res !== 32'h0000000F) begin miscompares++; $display("FAIL basic_result: got %h want 0000000f", res); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL basic_error: got %b want 0", err); end
  endtask

  task automatic test_mul_h_stall();
    int lat, vcnt; logic [31:0] res; logic err; bit stable, ok;
    run_op(1, 8'b01000_0_1_0, 32'hFFFFFFFF, 32'd2, 5, lat, vcnt, res, err, stable, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL stall_handshake: got %0d want 1", ok); end
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL stall_latency: got %0d want 34", lat); end
    vectors++; if (res !== 32'h00000001) begin miscompares++; $display("FAIL stall_result: got %h want 00000001", res); end
    vectors++; if (stable !== 1'b1) begin miscompares++; $display("FAIL stall_hold: got %0d want 1", stable); end
  endtask

  task automatic test_pw8();
    int lat, vcnt; logic [31:0] res; logic err; bit stable, ok;
    run_op(0, 8'b00010_0_0_1, 32'h02030405, 32'h02020202, 1, lat, vcnt, res, err, stable, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL pw8_handshake: got %0d want 1", ok); end
    vectors++; if (vcnt !== 9) begin miscompares++; $display("FAIL pw8_valid_cycles: got %0d want 9", vcnt); end
    vectors++; if (lat !== 10) begin miscompares++; $display("FAIL pw8_latency: got %0d want 10", lat); end
    vectors++; if (res !== 32'h0406080A) begin miscompares++; $display("FAIL pw8_result: got %h want 0406080a", res); end
  endtask

  task automatic test_reset_mid_op();
    int n, t0, bad;
    n = 0; bad = 0;
    @(negedge clock);
    drive_req(0, 1'b1, 8'b01000_0_0_1, $urandom, $urandom);
    #1;
    while (!req0_ready && n < 100) begin @(negedge clock); #1; n++; end
    t0 = cyc;
    @(negedge clock);
    drive_req(0, 1'b0, 8'h00, 32'h0, 32'h0);
    while (cyc - t0 < 10) @(negedge clock);
    #1;
    vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_busy: got %b want 1", m_valid); end
    resetn = 1'b0;
    #1;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid_drop: got %b want 0", m_valid); end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    ptr_m = (RR_INIT != 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock); #1;
      if (m_valid || rsp0_valid || rsp1_valid) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL midrst_no_response: got %0d active cycles want 0", bad); end
    drive_req(0, 1'b1, 8'b01000_0_0_1, 32'h1, 32'h1);
    drive_req(1, 1'b1, 8'b01000_0_0_1, 32'h1, 32'h1);
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== ((RR_INIT == 0) ? 2'b10 : 2'b01)) begin
      miscompares++;
      $display("FAIL midrst_grant: got %b want port %0d", {req0_ready, req1_ready}, RR_INIT);
    end
    #1;
    drive_req(0, 1'b0, 8'h00, 32'h0, 32'h0);
    drive_req(1, 1'b0, 8'h00, 32'h0, 32'h0);
  endtask

  task automatic test_round_robin();
    logic [7:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    int   grants[$];
    int   exp_first, nrsp, n, bad_both, bad_resp, bad_restart, bad_res;
    logic prev_fin;
    op0 = 8'b00100_0_0_1; op1 = 8'b00001_1_1_0;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    exp_first = ptr_m;
    nrsp = 0; n = 0; bad_both = 0; bad_resp = 0; bad_restart = 0; bad_res = 0; prev_fin = 1'b0;
    @(negedge clock);
    drive_req(0, 1'b1, op0, a0, b0);
    drive_req(1, 1'b1, op1, a1, b1);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    while (nrsp < 4 && n < 400) begin
      #1;
      if (req0_ready && req1_ready) bad_both++;
      if ((req0_ready || req1_ready) && (rsp0_valid || rsp1_valid)) bad_resp++;
      if (prev_fin && m_valid) bad_restart++;
      prev_fin = m_valid && m_ready;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp0_valid) begin nrsp++; if (rsp_result !== pmul(op0, a0, b0)) bad_res++; end
      if (rsp1_valid) begin nrsp++; if (rsp_result !== pmul(op1, a1, b1)) bad_res++; end
      if (nrsp >= 4) begin
        drive_req(0, 1'b0, op0, a0, b0);
        drive_req(1, 1'b0, op1, a1, b1);
      end
      @(negedge clock);
      n++;
    end
    drive_req(0, 1'b0, op0, a0, b0);
    drive_req(1, 1'b0, op1, a1, b1);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    if (grants.size() > 0) ptr_m = (grants[grants.size() - 1] == 0);
    vectors++; if (nrsp !== 4) begin miscompares++; $display("FAIL rr_responses: got %0d want 4", nrsp); end
    vectors++; if (grants.size() !== 4) begin miscompares++; $display("FAIL rr_grant_count: got %0d want 4", grants.size()); end
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      vectors++;
      if (grants[i] !== (exp_first ^ (i % 2))) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i, grants[i], exp_first ^ (i % 2));
      end
    end
    vectors++; if (bad_both !== 0) begin miscompares++; $display("FAIL rr_dual_ready: got %0d want 0", bad_both); end
    vectors++; if (bad_resp !== 0) begin miscompares++; $display("FAIL rr_grant_in_resp: got %0d want 0", bad_resp); end
    vectors++; if (bad_restart !== 0) begin miscompares++; $display("FAIL rr_valid_after_finish: got %0d want 0", bad_restart); end
    vectors++; if (bad_res !== 0) begin miscompares++; $display("FAIL rr_results: got %0d bad want 0", bad_res); end
  endtask

  task automatic test_random();
    int lat, vcnt, port, sel, kind, hold, exp_n;
    logic [31:0] res, a, b, exp_r;
    logic err;
    bit stable, ok;
    logic [7:0] op;
    logic [2:0] kbits;
    for (int k = 0; k < 24; k++) begin
      port = $urandom_range(0, 1);
      sel  = $urandom_range(0, 3);
      kind = $urandom_range(0, 3);
      hold = $urandom_range(0, 3);
      a = $urandom; b = $urandom;
      case (kind)
        0: kbits = 3'b001;
        1: kbits = 3'b010;
        2: kbits = 3'b101;
        default: kbits = 3'b110;
      endcase
      op = {5'(5'b00001 << sel), kbits};
      exp_n = (4 << sel) + 1;
      exp_r = pmul(op, a, b);
      run_op(port, op, a, b, hold, lat, vcnt, res, err, stable, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rnd_handshake[%0d]: got %0d want 1", k, ok); end
      vectors++; if (vcnt !== exp_n) begin miscompares++; $display("FAIL rnd_valid_cycles[%0d]: got %0d want %0d", k, vcnt, exp_n); end
      vectors++; if (lat !== exp_n + 1) begin miscompares++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", k, lat, exp_n + 1); end
      vectors++; if (res !== exp_r) begin miscompares++; $display("FAIL rnd_result[%0d]: got %h want %h (op %b)", k, res, exp_r, op); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rnd_error[%0d]: got %b want 0", k, err); end
      vectors++; if (stable !== 1'b1) begin miscompares++; $display("FAIL rnd_hold[%0d]: got %0d want 1", k, stable); end
    end
  endtask

`ifdef P_MUL_CTRL_PW_CHECK_EN
  task automatic test_illegal_pw();
    int lat, vcnt; logic [31:0] res; logic err; bit stable, ok;
    run_op(1, 8'b00011_0_0_1, $urandom, $urandom, 2, lat, vcnt, res, err, stable, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL illegal_handshake: got %0d want 1", ok); end
    vectors++; if (vcnt !== 0) begin miscompares++; $display("FAIL illegal_valid_cycles: got %0d want 0", vcnt); end
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL illegal_latency: got %0d want 1", lat); end
    vectors++; if (res !== 32'h0) begin miscompares++; $display("FAIL illegal_result: got %h want 00000000", res); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL illegal_error: got %b want 1", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_mul_l_basic();
    test_mul_h_stall();
    test_pw8();
    test_reset_mid_op();
    test_round_robin();
    test_random();
`ifdef P_MUL_CTRL_PW_CHECK_EN
    test_illegal_pw();
`endif
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
